// File: rtl/mux_pkg.sv
// Shared types and round-robin pick function for the 4-way bus arbiter.
package mux_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } pick_t;

  // First set bit scanning ptr+1, ptr+2, ptr+3, ptr (mod 4).
  function automatic pick_t rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    pick_t      r;
    logic [1:0] idx;
    r = '0;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr + 2'(k);
      if (!r.found && req[idx]) begin
        r.found = 1'b1;
        r.idx   = idx;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mux4w.sv
// Parameterised W-bit 4:1 combinational multiplexer.
module mux4w #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  input  logic [1:0]   sel,
  output logic [W-1:0] y_c
);

  always_comb begin
    y_c = d0;
    case (sel)
      2'd0:    y_c = d0;
      2'd1:    y_c = d1;
      2'd2:    y_c = d2;
      default: y_c = d3;
    endcase
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for a shared 4-way W-bit bus with a per-owner hold limit;
// registers the winner's word onto O aligned with the grant.
module mux4_rr_arbiter
  import mux_pkg::*;
#(
  parameter int unsigned W        = 4,
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   req,
  input  logic [W-1:0] I0,
  input  logic [W-1:0] I1,
  input  logic [W-1:0] I2,
  input  logic [W-1:0] I3,
  output logic [3:0]   gnt,
  output logic [1:0]   s,
  output logic [W-1:0] O,
  output logic         vld
);

  localparam int unsigned HCW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_MAX - 1);

  logic [0:0]     state, state_nxt;
  logic [1:0]     ptr, ptr_nxt;
  logic [HCW-1:0] hold_cnt, hold_nxt;
  logic [3:0]     gnt_nxt;
  logic [1:0]     s_nxt;
  logic           vld_nxt;
  logic           load_o;
  logic           take;
  logic [1:0]     win;
  logic [W-1:0]   mux_y;
  pick_t          pk_all;
  pick_t          pk_oth;

  // pk_oth excludes the current owner for the forced-rotate case; ptr==s while granted.
  always_comb begin
    pk_all = rr_pick(req, ptr);
    pk_oth = rr_pick(req & ~(4'b0001 << s), s);
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    hold_nxt  = hold_cnt;
    gnt_nxt   = gnt;
    s_nxt     = s;
    vld_nxt   = vld;
    load_o    = 1'b0;
    take      = 1'b0;
    win       = s;
    case (state)
      ST_IDLE: begin
        gnt_nxt = 4'b0000;
        vld_nxt = 1'b0;
        if (pk_all.found) begin
          take = 1'b1;
          win  = pk_all.idx;
        end
      end
      ST_GRANT: begin
        if (!req[s]) begin
          // Release: re-arbitrate immediately, no idle bubble if anyone is waiting.
          if (pk_all.found) begin
            take = 1'b1;
            win  = pk_all.idx;
          end else begin
            state_nxt = ST_IDLE;
            gnt_nxt   = 4'b0000;
            vld_nxt   = 1'b0;
          end
        end else if (hold_cnt == HOLD_LAST && pk_oth.found) begin
          take = 1'b1;
          win  = pk_oth.idx;
        end else begin
          load_o = 1'b1;
          if (hold_cnt != HOLD_LAST) hold_nxt = hold_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        gnt_nxt   = 4'b0000;
        vld_nxt   = 1'b0;
      end
    endcase

    if (take) begin
      state_nxt = ST_GRANT;
      ptr_nxt   = win;
      s_nxt     = win;
      gnt_nxt   = 4'b0001 << win;
      vld_nxt   = 1'b1;
      hold_nxt  = '0;
      load_o    = 1'b1;
    end
  end

  mux4w #(.W(W)) u_mux (
    .d0  (I0),
    .d1  (I1),
    .d2  (I2),
    .d3  (I3),
    .sel (s_nxt),
    .y_c (mux_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ptr      <= 2'd3;
      hold_cnt <= '0;
      gnt      <= 4'b0000;
      s        <= 2'd0;
      O        <= '0;
      vld      <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_nxt;
      gnt      <= gnt_nxt;
      s        <= s_nxt;
      vld      <= vld_nxt;
      if (load_o) O <= mux_y;
    end
  end

endmodule
